irq_phase_ctrl: RTL and testbench

- Parametrised phase sequencer and multi-channel interrupt controller for the stack CPU control path.
- Generates the FETCH/DECODE/EXEC/RDMEM instruction phases.
- Stretches memory phases by a configurable wait-state count.
- Arbitrates NUM_IRQ masked, prioritised interrupt lines into a single irq_pend with a vector address, which the signal-generation logic consumes.

---
 rtl/irq_phase_ctrl.sv | 157 +++++++++++++++
 tb/tb_irq_phase_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_phase_ctrl.sv
// Instruction phase sequencer (FETCH/DECODE/EXEC/RDMEM with memory wait states)
// plus a masked, fixed-priority interrupt controller feeding the signal-generation logic.
module irq_phase_ctrl #(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
    parameter int                 MEM_WAIT   = 0,
    parameter logic [15:0]        VEC_BASE   = 16'h0010,
    parameter int                 VEC_STRIDE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               insn_rd,
    input  logic               set_ien,
    input  logic               clear_ien,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [1:0]         phase,
    output logic               phase_fetch,
    output logic               phase_decode,
    output logic               phase_exec,
    output logic               phase_rdmem,
    output logic               phase_last,
    output logic               irq_pend,
    output logic [15:0]        irq_vec,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               ien,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int         SEL_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    typedef enum logic [1:0] {
        PH_DECODE = 2'd0,
        PH_EXEC   = 2'd1,
        PH_RDMEM  = 2'd2,
        PH_FETCH  = 2'd3
    } phase_t;

    phase_t             state;
    phase_t             state_next;
    logic [2:0]         wait_cnt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] masked;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_next;
    logic [15:0]        vec_next;
    logic               take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PH_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Memory phases reload the counter whenever a phase ends, so entry always starts at MEM_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= WAIT_INIT;
        end else if (phase_last) begin
            wait_cnt <= WAIT_INIT;
        end else begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PH_FETCH:  if (phase_last) state_next = PH_DECODE;
            PH_DECODE: state_next = PH_EXEC;
            PH_EXEC:   state_next = (insn_rd && !irq_pend) ? PH_RDMEM : PH_FETCH;
            PH_RDMEM:  if (phase_last) state_next = PH_FETCH;
            default:   state_next = PH_FETCH;
        endcase
    end

    always_comb begin
        phase        = state;
        phase_fetch  = (state == PH_FETCH);
        phase_decode = (state == PH_DECODE);
        phase_exec   = (state == PH_EXEC);
        phase_rdmem  = (state == PH_RDMEM);
        phase_last   = 1'b1;
        if (state == PH_FETCH || state == PH_RDMEM) begin
            phase_last = (wait_cnt == 3'd0);
        end
        irq_ack = '0;
        if (state == PH_EXEC && irq_pend) begin
            irq_ack[sel] = 1'b1;
        end
    end

    // Edge channels latch until acknowledged; a fresh edge in the ack cycle keeps them set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q     <= '0;
            edge_pend <= '0;
        end else begin
            irq_q     <= irq;
            edge_pend <= ((edge_pend & ~irq_ack) | (irq & ~irq_q)) & EDGE_MASK;
        end
    end

    assign pending = (edge_pend & EDGE_MASK) | (irq & ~EDGE_MASK);
    assign masked  = pending & mask_q;
    assign take    = (state == PH_FETCH) && phase_last;

    always_comb begin
        sel_next = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) sel_next = SEL_W'(i);
        end
        vec_next = VEC_BASE + 16'(sel_next) * 16'(VEC_STRIDE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pend <= 1'b0;
            sel      <= '0;
            irq_vec  <= VEC_BASE;
        end else if (take) begin
            irq_pend <= ien && (|masked);
            if (|masked) begin
                sel     <= sel_next;
                irq_vec <= vec_next;
            end
        end
    end

    // Entering an interrupt slot drops the global enable; clear beats set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien <= 1'b0;
        end else if (state == PH_EXEC) begin
            if (clear_ien || irq_pend) begin
                ien <= 1'b0;
            end else if (set_ien) begin
                ien <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_wdata;
        end
    end

endmodule

// File: tb/tb_irq_phase_ctrl.sv
// Bench for irq_phase_ctrl: directed scenarios then random traffic, every cycle
// compared against a cycle-count/queue-free behavioural model of the phase and interrupt rules.
module tb_irq_phase_ctrl;

    localparam int          NUM_IRQ    = 4;
    localparam logic [3:0]  EDGE_MASK  = 4'b0001;
    localparam int          MEM_WAIT   = 2;
    localparam logic [15:0] VEC_BASE   = 16'h0010;
    localparam int          VEC_STRIDE = 2;

    localparam int P_DECODE = 0;
    localparam int P_EXEC   = 1;
    localparam int P_RDMEM  = 2;
    localparam int P_FETCH  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq = '0;
    logic        insn_rd = 1'b0;
    logic        set_ien = 1'b0;
    logic        clear_ien = 1'b0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wdata = '0;
    logic [1:0]  phase;
    logic        phase_fetch, phase_decode, phase_exec, phase_rdmem, phase_last;
    logic        irq_pend;
    logic [15:0] irq_vec;
    logic [3:0]  irq_ack;
    logic        ien;
    logic [3:0]  pending;

    logic [3:0]  t_irq = '0;
    logic        t_insn = 1'b0, t_set = 1'b0, t_clr = 1'b0, t_mwe = 1'b0;
    logic [3:0]  t_mwd = '0;

    int n_vec = 0;
    int n_miscompare = 0;

    int          m_phase, m_left, m_sel;
    logic        m_pend, m_ien;
    logic [3:0]  m_mask, m_edge, m_prev;
    logic [15:0] m_vec;

    irq_phase_ctrl #(
        .NUM_IRQ(NUM_IRQ), .EDGE_MASK(EDGE_MASK), .MEM_WAIT(MEM_WAIT),
        .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq), .insn_rd(insn_rd),
        .set_ien(set_ien), .clear_ien(clear_ien), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .phase(phase), .phase_fetch(phase_fetch), .phase_decode(phase_decode),
        .phase_exec(phase_exec), .phase_rdmem(phase_rdmem), .phase_last(phase_last),
        .irq_pend(irq_pend), .irq_vec(irq_vec), .irq_ack(irq_ack), .ien(ien), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic int phase_len(input int p);
        return (p == P_FETCH || p == P_RDMEM) ? MEM_WAIT + 1 : 1;
    endfunction

    function automatic logic [3:0] exp_pending();
        return (m_edge & EDGE_MASK) | (irq & ~EDGE_MASK);
    endfunction

    function automatic logic [3:0] exp_ack();
        return (m_phase == P_EXEC && m_pend) ? 4'(1 << m_sel) : 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miscompare++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic modelReset();
        m_phase = P_FETCH;
        m_left  = phase_len(P_FETCH);
        m_sel   = 0;
        m_pend  = 1'b0;
        m_ien   = 1'b0;
        m_mask  = '0;
        m_edge  = '0;
        m_prev  = '0;
        m_vec   = VEC_BASE;
    endtask

    task automatic modelStep();
        logic [3:0] masked, ack;
        logic       old_pend;
        int         nxt;
        masked   = exp_pending() & m_mask;
        ack      = exp_ack();
        old_pend = m_pend;
        if (m_phase == P_FETCH && m_left == 1) begin
            m_pend = m_ien && (masked != 4'b0);
            if (masked != 4'b0) begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (masked[i]) begin
                        m_sel = i;
                        break;
                    end
                end
                m_vec = 16'(int'(VEC_BASE) + m_sel * VEC_STRIDE);
            end
        end
        if (m_phase == P_EXEC) begin
            if (clear_ien || old_pend) m_ien = 1'b0;
            else if (set_ien)          m_ien = 1'b1;
        end
        if (mask_we) m_mask = mask_wdata;
        m_edge = ((m_edge & ~ack) | (irq & ~m_prev)) & EDGE_MASK;
        m_prev = irq;
        if (m_left > 1) begin
            m_left--;
        end else begin
            case (m_phase)
                P_FETCH:  nxt = P_DECODE;
                P_DECODE: nxt = P_EXEC;
                P_EXEC:   nxt = (insn_rd && !old_pend) ? P_RDMEM : P_FETCH;
                default:  nxt = P_FETCH;
            endcase
            m_phase = nxt;
            m_left  = phase_len(nxt);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] oh;
        case (m_phase)
            P_FETCH:  oh = 4'b1000;
            P_DECODE: oh = 4'b0100;
            P_EXEC:   oh = 4'b0010;
            default:  oh = 4'b0001;
        endcase
        chk("phase", 16'(phase), 16'(m_phase));
        chk("phase_flags", 16'({phase_fetch, phase_decode, phase_exec, phase_rdmem}), 16'(oh));
        chk("phase_last", 16'(phase_last), 16'(m_left == 1));
        chk("pending", 16'(pending), 16'(exp_pending()));
        chk("irq_ack", 16'(irq_ack), 16'(exp_ack()));
        chk("ien", 16'(ien), 16'(m_ien));
        if (m_phase == P_DECODE || m_phase == P_EXEC) begin
            chk("irq_pend", 16'(irq_pend), 16'(m_pend));
            if (m_pend) chk("irq_vec", irq_vec, m_vec);
        end
    endtask

    // One clock cycle: drive staged inputs mid-low phase, check, then advance the model.
    task automatic applyStimulus();
        @(negedge clk);
        irq        = t_irq;
        insn_rd    = t_insn;
        set_ien    = t_set;
        clear_ien  = t_clr;
        mask_we    = t_mwe;
        mask_wdata = t_mwd;
        #1;
        checkOutput();
        modelStep();
    endtask

    task automatic runTo(input int target);
        int n;
        n = 0;
        while (m_phase != target && n < 40) begin
            applyStimulus();
            n++;
        end
        if (m_phase != target) begin
            n_vec++;
            n_miscompare++;
            $error("[TB] FAIL runTo_timeout observed=%0d expected=%0d", m_phase, target);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        t_irq = '0; t_set = 1'b0; t_clr = 1'b0; t_mwe = 1'b0;
        irq = '0; set_ien = 1'b0; clear_ien = 1'b0; mask_we = 1'b0;
        #1;
        modelReset();
        chk("rst_phase", 16'(phase), 16'(P_FETCH));
        chk("rst_phase_last", 16'(phase_last), 16'(MEM_WAIT == 0));
        chk("rst_irq_pend", 16'(irq_pend), 16'h0);
        chk("rst_irq_vec", irq_vec, 16'h0010);
        chk("rst_irq_ack", 16'(irq_ack), 16'h0);
        chk("rst_ien", 16'(ien), 16'h0);
        chk("rst_pending", 16'(pending), 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        doReset();

        t_insn = 1'b1;
        repeat (16) applyStimulus();
        t_insn = 1'b0;
        repeat (12) applyStimulus();
        t_insn = 1'b1;

        // ien: ignored in DECODE, set in EXEC, clear beats set
        runTo(P_DECODE);
        t_set = 1'b1; applyStimulus(); t_set = 1'b0;
        applyStimulus();
        chk("ien_decode_ignored", 16'(ien), 16'h0);
        runTo(P_EXEC);
        t_set = 1'b1; applyStimulus(); t_set = 1'b0;
        applyStimulus();
        chk("ien_set", 16'(ien), 16'h1);
        runTo(P_EXEC);
        t_set = 1'b1; t_clr = 1'b1; applyStimulus(); t_set = 1'b0; t_clr = 1'b0;
        applyStimulus();
        chk("ien_clear_wins", 16'(ien), 16'h0);
        runTo(P_EXEC);
        t_set = 1'b1; applyStimulus(); t_set = 1'b0;

        // Level interrupts on channels 1 and 3: channel 1 wins
        t_mwe = 1'b1; t_mwd = 4'b1111; applyStimulus(); t_mwe = 1'b0;
        runTo(P_DECODE);
        t_irq = 4'b1010;
        runTo(P_FETCH);
        runTo(P_EXEC);
        applyStimulus();
        chk("lvl_irq_pend", 16'(irq_pend), 16'h1);
        chk("lvl_irq_vec", irq_vec, 16'h0012);
        chk("lvl_irq_ack", 16'(irq_ack), 16'h0002);
        t_irq = 4'b0000;
        applyStimulus();
        chk("lvl_no_rdmem", 16'(phase), 16'(P_FETCH));
        chk("lvl_ien_cleared", 16'(ien), 16'h0);

        // Edge channel 0: pulse in DECODE, second pulse coincident with ack
        runTo(P_EXEC);
        t_set = 1'b1; applyStimulus(); t_set = 1'b0;
        runTo(P_DECODE);
        t_irq = 4'b0001; applyStimulus(); t_irq = 4'b0000;
        applyStimulus();
        chk("edge_latched", 16'(pending[0]), 16'h1);
        runTo(P_FETCH);
        runTo(P_EXEC);
        t_irq = 4'b0001; applyStimulus(); t_irq = 4'b0000;
        chk("edge_irq_vec", irq_vec, 16'h0010);
        chk("edge_irq_ack", 16'(irq_ack), 16'h0001);
        applyStimulus();
        chk("edge_wins_over_ack", 16'(pending[0]), 16'h1);

        for (int i = 0; i < 400; i++) begin
            t_irq  = 4'($urandom);
            t_insn = 1'($urandom);
            t_set  = ($urandom_range(0, 3) == 0);
            t_clr  = ($urandom_range(0, 5) == 0);
            t_mwe  = ($urandom_range(0, 7) == 0);
            t_mwd  = 4'($urandom);
            applyStimulus();
        end
        t_irq = '0; t_set = 1'b0; t_clr = 1'b0; t_mwe = 1'b0; t_insn = 1'b1;

        // Reset in the middle of RDMEM with an edge request held
        runTo(P_EXEC);
        t_clr = 1'b1; applyStimulus(); t_clr = 1'b0;
        runTo(P_DECODE);
        t_irq = 4'b0001; applyStimulus(); t_irq = 4'b0000;
        runTo(P_RDMEM);
        applyStimulus();
        chk("edge_held_in_rdmem", 16'(pending[0]), 16'h1);
        doReset();
        repeat (10) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
